// File: rtl/conv_sequencer_pkg.sv
// Shared widths and one-hot FSM encoding for the convolution sequencer.
`ifndef CONV_SEQ_DEFS
`define CONV_SEQ_DEFS
`define bitLength 16
`define inputPortCount 3
`define addressLength 8
`endif

package conv_sequencer_pkg;

  localparam int BIT_LENGTH_D = `bitLength;
  localparam int PORT_COUNT_D = `inputPortCount;
  localparam int WD_WIDTH     = 8;

  typedef enum logic [8:0] {
    S_IDLE       = 9'b000000001,
    S_CLEAR      = 9'b000000010,
    S_LOAD       = 9'b000000100,
    S_START      = 9'b000001000,
    S_WAIT_MUL   = 9'b000010000,
    S_FINAL      = 9'b000100000,
    S_WAIT_FINAL = 9'b001000000,
    S_OUT        = 9'b010000000,
    S_ERROR      = 9'b100000000
  } state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog for the accelerator wait states.
// expired fires during the TIMEOUT-th consecutive run cycle after clr.
module seq_watchdog
  import conv_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [WD_WIDTH-1:0] LAST = WD_WIDTH'(TIMEOUT - 1);

  logic [WD_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/conv_sequencer.sv
// Feeds kernel rows to the matrix accelerator, collects the final
// sum and presents it on a valid/ready result port.
module conv_sequencer
  import conv_sequencer_pkg::*;
#(
  parameter int BIT_LENGTH  = BIT_LENGTH_D,
  parameter int PORT_COUNT  = PORT_COUNT_D,
  parameter int KERNEL_ROWS = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             en,
  input  logic                             win_valid,
  output logic                             win_ready,
  input  logic [PORT_COUNT*BIT_LENGTH-1:0] win_pixel,
  input  logic [PORT_COUNT*BIT_LENGTH-1:0] win_kernel,
  output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplier_input,
  output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplicand_input,
  output logic [PORT_COUNT-1:0]            mStart,
  input  logic [PORT_COUNT-1:0]            mReady,
  output logic                             acc_clr,
  output logic                             finalAdd,
  input  logic [2*BIT_LENGTH-1:0]          finalAccumulate,
  input  logic                             finalReady,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [2*BIT_LENGTH-1:0]          res_data,
  output logic                             busy,
  output logic                             err
);

  localparam int W  = PORT_COUNT * BIT_LENGTH;
  localparam int RW = (KERNEL_ROWS > 1) ? $clog2(KERNEL_ROWS) : 1;

  state_e                  state_q, state_d;
  logic [W-1:0]            mul_q, mul_d;
  logic [W-1:0]            mcd_q, mcd_d;
  logic [PORT_COUNT-1:0]   mask_q, mask_d;
  logic [RW-1:0]           row_q, row_d;
  logic [2*BIT_LENGTH-1:0] res_q, res_d;
  logic                    all_rdy;
  logic                    last_row;
  logic                    expired;

  // Ready bits landing in the same cycle as the last missing one count.
  assign all_rdy  = &(mask_q | mReady);
  assign last_row = (row_q == RW'(KERNEL_ROWS - 1));

  always_comb begin
    state_d = state_q;
    mul_d   = mul_q;
    mcd_d   = mcd_q;
    mask_d  = mask_q;
    row_d   = row_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: if (en) state_d = S_CLEAR;
      S_CLEAR: begin
        row_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: if (win_valid) begin
        mul_d   = win_pixel;
        mcd_d   = win_kernel;
        state_d = S_START;
      end
      S_START: begin
        mask_d  = '0;
        state_d = S_WAIT_MUL;
      end
      S_WAIT_MUL: begin
        mask_d = mask_q | mReady;
        if (all_rdy) begin
          if (last_row) begin
            state_d = S_FINAL;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_LOAD;
          end
        end else if (expired) begin
          state_d = S_ERROR;
        end
      end
      S_FINAL: state_d = S_WAIT_FINAL;
      S_WAIT_FINAL: begin
        if (finalReady) begin
          res_d   = finalAccumulate;
          state_d = S_OUT;
        end else if (expired) begin
          state_d = S_ERROR;
        end
      end
      S_OUT: if (res_ready) state_d = en ? S_CLEAR : S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    // A hung accelerator leaves every data output quiet.
    if (state_d == S_ERROR) begin
      mul_d = '0;
      mcd_d = '0;
      res_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      mul_q   <= '0;
      mcd_q   <= '0;
      mask_q  <= '0;
      row_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mul_q   <= mul_d;
      mcd_q   <= mcd_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
      res_q   <= res_d;
    end
  end

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .Clk     (Clk),
    .Rst     (Rst),
    .clr     ((state_q == S_START) || (state_q == S_FINAL)),
    .run     ((state_q == S_WAIT_MUL) || (state_q == S_WAIT_FINAL)),
    .expired (expired)
  );

  assign win_ready          = (state_q == S_LOAD);
  assign mStart             = {PORT_COUNT{state_q == S_START}};
  assign acc_clr            = (state_q == S_CLEAR);
  assign finalAdd           = (state_q == S_FINAL);
  assign res_valid          = (state_q == S_OUT);
  assign busy               = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign err                = (state_q == S_ERROR);
  assign multiplier_input   = mul_q;
  assign multiplicand_input = mcd_q;
  assign res_data           = res_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer with a small accelerator model.
module tb_conv_sequencer;

  localparam int BL = 16;
  localparam int PC = 3;
  localparam int KR = 3;
  localparam int TO = 255;
  localparam int W  = PC * BL;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          en = 1'b0;
  logic          win_valid = 1'b0;
  logic          win_ready;
  logic [W-1:0]  win_pixel = '0;
  logic [W-1:0]  win_kernel = '0;
  logic [W-1:0]  multiplier_input;
  logic [W-1:0]  multiplicand_input;
  logic [PC-1:0] mStart;
  logic [PC-1:0] mReady = '0;
  logic          acc_clr;
  logic          finalAdd;
  logic [2*BL-1:0] finalAccumulate = '0;
  logic          finalReady = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [2*BL-1:0] res_data;
  logic          busy;
  logic          err;

  conv_sequencer #(
    .BIT_LENGTH  (BL),
    .PORT_COUNT  (PC),
    .KERNEL_ROWS (KR),
    .TIMEOUT     (TO)
  ) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .en                 (en),
    .win_valid          (win_valid),
    .win_ready          (win_ready),
    .win_pixel          (win_pixel),
    .win_kernel         (win_kernel),
    .multiplier_input   (multiplier_input),
    .multiplicand_input (multiplicand_input),
    .mStart             (mStart),
    .mReady             (mReady),
    .acc_clr            (acc_clr),
    .finalAdd           (finalAdd),
    .finalAccumulate    (finalAccumulate),
    .finalReady         (finalReady),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .busy               (busy),
    .err                (err)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #2;
  endtask

  // Accelerator model: per-port ready delay, one-cycle finalReady.
  int   dly[PC] = '{1, 1, 1};
  bit   hold[PC] = '{0, 0, 0};
  int   cd[PC] = '{0, 0, 0};
  bit   fcd = 0;
  logic [2*BL-1:0] acc = '0;

  always @(negedge Clk) begin
    if (!Rst) begin
      for (int p = 0; p < PC; p++) cd[p] = 0;
      mReady = '0;
      finalReady = 1'b0;
      fcd = 0;
    end else begin
      for (int p = 0; p < PC; p++) begin
        if (mStart[p]) begin
          cd[p] = dly[p];
          mReady[p] = 1'b0;
        end else if (cd[p] > 0) begin
          cd[p]--;
          mReady[p] = (cd[p] == 0) && !hold[p];
        end else begin
          mReady[p] = 1'b0;
        end
      end
      if (acc_clr) acc = '0;
      if (mStart[0])
        for (int p = 0; p < PC; p++)
          acc += 32'(multiplier_input[p*BL +: BL])
               * 32'(multiplicand_input[p*BL +: BL]);
      if (fcd) begin
        finalReady = 1'b1;
        finalAccumulate = acc;
        fcd = 0;
      end else begin
        finalReady = 1'b0;
        if (finalAdd) fcd = 1;
      end
    end
  end

  // Pulse counters and timing marks.
  int n_ms = 0, n_fa = 0, n_clr = 0;
  int clr_cyc = 0, rv_cyc = 0, ms_cyc = 0, last_gap = 0;
  bit rv_prev = 0, wr_prev = 0;

  always @(negedge Clk) begin
    if (mStart != '0) begin
      n_ms++;
      ms_cyc = cyc;
    end
    if (finalAdd) n_fa++;
    if (acc_clr) begin
      n_clr++;
      clr_cyc = cyc;
    end
    if (res_valid && !rv_prev) rv_cyc = cyc;
    if (win_ready && !wr_prev) last_gap = cyc - ms_cyc;
    rv_prev = res_valid;
    wr_prev = win_ready;
  end

  // Result scoreboard monitor.
  logic [2*BL-1:0] exp_q[$];
  bit              held = 0;
  logic [2*BL-1:0] held_v;

  always @(negedge Clk) begin
    #3;
    if (Rst && res_valid) begin
      if (held) check("res_stable", res_data, held_v);
      held = 1;
      held_v = res_data;
      if (res_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL res_extra: got %0d, want no result", res_data);
        end else begin
          check("res_data", res_data, exp_q.pop_front());
        end
        held = 0;
      end
    end else begin
      held = 0;
    end
  end

  logic [W-1:0] PIX[3][3];
  logic [W-1:0] KER[3][3];
  logic [W-1:0] last_pix, last_ker;
  bit           have_prev = 0;

  function automatic logic [W-1:0] row3(input int a, input int b, input int c);
    return {BL'(c), BL'(b), BL'(a)};
  endfunction

  task automatic send_row(input logic [W-1:0] pix, input logic [W-1:0] ker,
                          input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      tick();
      if (have_prev) begin
        check("op_hold_pix", multiplier_input, last_pix);
        check("op_hold_ker", multiplicand_input, last_ker);
      end
    end
    win_pixel = pix;
    win_kernel = ker;
    win_valid = 1'b1;
    n = 0;
    while (!win_ready && n < 400) begin
      tick();
      n++;
    end
    if (!win_ready) begin
      tests++;
      fails++;
      $display("FAIL win_ready_wait: got 0 after %0d cycles, want 1", n);
    end
    tick();
    win_valid = 1'b0;
    check("op_pix", multiplier_input, pix);
    check("op_ker", multiplicand_input, ker);
    last_pix = pix;
    last_ker = ker;
    have_prev = 1;
  endtask

  task automatic do_rows(input int s, input int gap);
    for (int r = 0; r < KR; r++) send_row(PIX[s][r], KER[s][r], gap);
  endtask

  task automatic wait_rv();
    int n = 0;
    while (!res_valid && n < 400) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      tests++;
      fails++;
      $display("FAIL res_valid_wait: got 0 after %0d cycles, want 1", n);
    end
  endtask

  task automatic accept_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check(name, {win_ready, mStart, acc_clr, finalAdd, res_valid, busy, err}, 0);
  endtask

  int b_ms, b_fa, b_clr, n;

  initial begin
    PIX[0][0] = row3(1, 2, 3);    KER[0][0] = row3(1, 1, 1);
    PIX[0][1] = row3(4, 5, 6);    KER[0][1] = row3(1, 1, 1);
    PIX[0][2] = row3(7, 8, 9);    KER[0][2] = row3(1, 1, 1);
    PIX[1][0] = row3(1, 1, 1);    KER[1][0] = row3(1, 2, 3);
    PIX[1][1] = row3(2, 2, 2);    KER[1][1] = row3(1, 2, 3);
    PIX[1][2] = row3(3, 3, 3);    KER[1][2] = row3(1, 2, 3);
    PIX[2][0] = row3(10, 20, 30); KER[2][0] = row3(2, 3, 4);
    PIX[2][1] = row3(1, 1, 1);    KER[2][1] = row3(100, 200, 300);
    PIX[2][2] = row3(0, 0, 5);    KER[2][2] = row3(7, 7, 7);

    // Reset state
    tick();
    tick();
    check_quiet("reset_ctl");
    check("reset_ops", {multiplier_input, multiplicand_input}, 0);
    check("reset_res", res_data, 0);
    Rst = 1'b1;
    repeat (3) tick();
    check("idle_no_en", {busy, win_ready}, 0);

    // Nominal window
    b_ms = n_ms; b_fa = n_fa; b_clr = n_clr;
    exp_q.push_back(45);
    en = 1'b1;
    tick();
    en = 1'b0;
    do_rows(0, 0);
    wait_rv();
    check("nom_latency", rv_cyc - clr_cyc, 12);
    check("nom_mstart", n_ms - b_ms, 3);
    check("nom_finaladd", n_fa - b_fa, 1);
    check("nom_accclr", n_clr - b_clr, 1);
    accept_res();
    tick();
    check("nom_idle", busy, 0);

    // Staggered ready
    dly[0] = 1; dly[1] = 5; dly[2] = 3;
    exp_q.push_back(36);
    en = 1'b1;
    tick();
    en = 1'b0;
    send_row(PIX[1][0], KER[1][0], 0);
    send_row(PIX[1][1], KER[1][1], 0);
    check("stagger_gap", last_gap, 6);
    send_row(PIX[1][2], KER[1][2], 0);
    wait_rv();
    accept_res();
    dly[0] = 1; dly[1] = 1; dly[2] = 1;

    // Backpressure
    b_ms = n_ms; b_fa = n_fa; b_clr = n_clr;
    exp_q.push_back(835);
    en = 1'b1;
    tick();
    en = 1'b0;
    do_rows(2, 4);
    wait_rv();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 835);
      tick();
    end
    check("bp_mstart", n_ms - b_ms, 3);
    check("bp_finaladd", n_fa - b_fa, 1);
    check("bp_accclr", n_clr - b_clr, 1);
    accept_res();

    // Watchdog
    hold[1] = 1;
    en = 1'b1;
    tick();
    en = 1'b0;
    send_row(PIX[0][0], KER[0][0], 0);
    n = 0;
    while (!err && n < 400) begin
      tick();
      n++;
    end
    check("wd_err", err, 1);
    check("wd_cycles", cyc - (ms_cyc + 1), TO);
    check("wd_busy", busy, 0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wd_hold", {win_ready, mStart, acc_clr, finalAdd, res_valid, busy, err}, 1);
    end
    en = 1'b0;
    Rst = 1'b0;
    #1;
    check_quiet("wd_rst");
    tick();
    Rst = 1'b1;
    hold[1] = 0;
    have_prev = 0;
    tick();

    // Reset mid-window
    en = 1'b1;
    tick();
    en = 1'b0;
    send_row(PIX[0][0], KER[0][0], 0);
    send_row(PIX[0][1], KER[0][1], 0);
    tick();
    check("mid_in_wait", busy, 1);
    Rst = 1'b0;
    #1;
    check_quiet("mid_rst_ctl");
    check("mid_rst_ops", {multiplier_input, multiplicand_input}, 0);
    check("mid_rst_res", res_data, 0);
    tick();
    Rst = 1'b1;
    have_prev = 0;
    tick();
    exp_q.push_back(45);
    en = 1'b1;
    tick();
    en = 1'b0;
    do_rows(0, 0);
    wait_rv();
    accept_res();

    // Back-to-back
    exp_q.push_back(45);
    exp_q.push_back(36);
    en = 1'b1;
    tick();
    do_rows(0, 0);
    wait_rv();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("b2b_clear", acc_clr, 1);
    en = 1'b0;
    do_rows(1, 0);
    wait_rv();
    accept_res();

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    check("end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

- Upstream control stage for the matrix accelerator.
- Accepts one convolution window as a sequence of kernel rows (one pixel row plus one kernel row per handshake).
- Drives the accelerator's multiplier/multiplicand buses and `mStart`, and collects per-port `mReady`.
- After the last row, issues `finalAdd`, captures `finalAccumulate` on `finalReady`, and presents the sum on a valid/ready result port.
- A watchdog flags a hung accelerator.

## Interface
Parameters:
- `BIT_LENGTH`, 16: operand width, equals `` `bitLength ``.
- `PORT_COUNT`, 3: multiplier ports, equals `` `inputPortCount ``.
- `KERNEL_ROWS`, 3: rows per window.
- `TIMEOUT`, 255: max wait cycles in WAIT_MUL / WAIT_FINAL.

Ports:
- `Clk` in 1: single clock; all logic is on its rising edge.
- `Rst` in 1: asynchronous, active-low reset.
- `en` in 1: level enable; leaving IDLE requires `en`=1.
- `win_valid` in 1: row operands valid.
- `win_ready` out 1: row accept.
- `win_pixel` in PORT_COUNT*BIT_LENGTH: flat pixel row, port 0 in the LSBs.
- `win_kernel` in PORT_COUNT*BIT_LENGTH: flat kernel row, port 0 in the LSBs.
- `multiplier_input` out PORT_COUNT*BIT_LENGTH: registered pixel row.
- `multiplicand_input` out PORT_COUNT*BIT_LENGTH: registered kernel row.
- `mStart` out PORT_COUNT: one-cycle start pulse, all bits equal.
- `mReady` in PORT_COUNT: per-port done; may be a pulse or a level.
- `acc_clr` out 1: one-cycle accelerator accumulator clear, active-high.
- `finalAdd` out 1: one-cycle final-add pulse.
- `finalAccumulate` in 2*BIT_LENGTH: accelerator sum.
- `finalReady` in 1: sum valid.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result accept.
- `res_data` out 2*BIT_LENGTH: captured sum.
- `busy` out 1: high in any state other than IDLE or ERROR.
- `err` out 1: sticky watchdog error.

## Operation
- States: IDLE, CLEAR, LOAD, START, WAIT_MUL, FINAL, WAIT_FINAL, OUT, ERROR.
- IDLE → CLEAR when `en`=1.
- CLEAR: `acc_clr`=1; row counter ← 0; → LOAD.
- LOAD: `win_ready`=1.
  - On `win_valid`&`win_ready`, register `win_pixel`/`win_kernel` onto `multiplier_input`/`multiplicand_input`, then → START.
  - Operand outputs are held stable until the next accept.
- START: `mStart`=all ones for one cycle; clear the ready mask and watchdog; → WAIT_MUL.
- WAIT_MUL: mask ← mask | `mReady`. Done when &(mask | `mReady`), so bits arriving in the same cycle count.
  - On done with row < KERNEL_ROWS-1: row++ and → LOAD.
  - On done with the last row: → FINAL.
- FINAL: `finalAdd`=1 for one cycle; clear the watchdog; → WAIT_FINAL.
- WAIT_FINAL: on `finalReady`, `res_data` ← `finalAccumulate`; → OUT.
- OUT: `res_valid`=1.
  - `res_data` is stable until accepted.
  - On `res_ready`: → CLEAR if `en`, else → IDLE.
- Watchdog: counts cycles spent in WAIT_MUL/WAIT_FINAL.
  - If it reaches TIMEOUT without completion: → ERROR; `err`=1.
  - In ERROR all outputs are idle except `err`. Only `Rst` exits ERROR.
  - Completion in the same cycle the count reaches TIMEOUT takes priority (no error).
- `en` dropped mid-window does not abort; it is sampled only in IDLE and OUT.
- `mReady` outside WAIT_MUL and `finalReady` outside WAIT_FINAL are ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: `win_ready`, `mStart`, `acc_clr`, `finalAdd`, `res_valid`, `busy`, `err`.
  - `multiplier_input`, `multiplicand_input`, `res_data` = 0.
  - Async assertion takes effect immediately, including mid-window; no partial result is emitted.
- Row accept at edge N:
  - Operands valid after N.
  - `mStart` high in cycle N+1.
  - `mReady` is sampled from cycle N+2 onward.
- Minimum window latency (zero-wait `win_valid`, `mReady` one cycle after `mStart`, `finalReady` one cycle after `finalAdd`):
  - 1 (CLEAR) + 3×KERNEL_ROWS (LOAD/START/WAIT) + 2 (FINAL/WAIT_FINAL).
  - This is 12 cycles from CLEAR to `res_valid`=1 at the defaults.
- `win_ready` is combinational from state only, with no dependence on `win_valid`.
- `res_valid` does not drop without `res_ready`.

## Structure
- Shared header/package holds:
  - `` `bitLength ``, `` `inputPortCount ``, `` `addressLength ``.
  - The state encoding constants (one-hot, 9 bits).
- The 8-bit watchdog is a sub-module, `seq_watchdog`, with ports `Clk`, `Rst`, `clr`, `run`, `expired`.
- The FSM, operand registers and mask stay in `conv_sequencer`.

## Test plan
- Nominal window:
  - Stimulus: rows pixel (1,2,3)/(4,5,6)/(7,8,9) with kernel all ones; `mReady` pulsed one cycle after `mStart`; model `finalAccumulate`=45.
  - Required: `res_data`=45; `res_valid` in cycle 12 after CLEAR; exactly 3 `mStart` pulses, 1 `finalAdd`, 1 `acc_clr`.
- Staggered ready:
  - Stimulus: `mReady` bits arrive as port0 at +1, port2 at +3, port1 at +5.
  - Required: stays in WAIT_MUL until +5; next `win_ready` at +6.
- Backpressure:
  - Stimulus: `win_valid` gapped 4 cycles per row; `res_ready` held low 10 cycles.
  - Required: operands and `res_data` stable throughout; no extra pulses.
- Watchdog:
  - Stimulus: withhold port1 `mReady`.
  - Required: `err`=1 and `busy`=0 exactly TIMEOUT cycles after WAIT_MUL entry; ERROR held; only `Rst` clears it.
- Reset mid-window:
  - Stimulus: assert `Rst` low during WAIT_MUL of row 1.
  - Required: all outputs 0 immediately; a following window produces the correct sum.
- Back-to-back:
  - Stimulus: `en`=1 and `res_ready`=1 on the first OUT cycle.
  - Required: CLEAR on the next cycle; two correct results.
